d7s_scan_ctrl: RTL and testbench
================================

Name: d7s_scan_ctrl

Overview:
Sequencing controller for the 3-digit seven-segment readout of the processor's 8-bit result bus.
- Accepts a binary value through a load handshake.
- Converts it to BCD with an 8-step shift-add-3 sequence, one step per cycle.
- Holds the BCD result and time-multiplexes three digits onto one shared active-low segment bus with active-low digit enables.
- Sits between the register-file/memory read path and the board display pins; replaces three parallel combinational decoders with one.

Parameters:
SCAN_DIV, 50000, clock cycles each digit stays enabled before the scan advances; legal range ≥1.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
value_in  input  8  unsigned binary value to display
load  input  1  request to convert value_in; sampled only when busy=0
busy  output  1  conversion in progress; load ignored while high
done  output  1  one-cycle pulse when a new BCD result is committed
bcd  output  12  committed result {hundreds, tens, units}, 4 bits each
seg  output  7  active-low segments {g,f,e,d,c,b,a} for the enabled digit
an  output  3  active-low one-hot digit enable; bit0 = units, bit1 = tens, bit2 = hundreds

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high; it takes effect only on a clk edge with reset=1.
- Reset values:
  - State IDLE; busy=0, done=0, bcd=12'h000.
  - Internal shift/scratch registers 0; step counter 0; scan counter 0; digit index 0.
  - Therefore an=3'b110 and seg=7'b1000000 (digit "0").
- States: IDLE, CONV.
  - IDLE: load=1 at edge N captures value_in into the shift register, clears the scratch BCD, sets step=0 and enters CONV. busy=1 after edge N.
  - CONV: at each edge N+1..N+8, every scratch nibble ≥5 gets +3, then {scratch, shift} shifts left by 1 and step increments.
  - At edge N+8 (8th shift): bcd ← scratch result, done=1 for exactly that cycle, busy=0, state returns to IDLE.
- Load-to-done latency is exactly 8 cycles. Values 0..255 yield hundreds 0..2, tens/units 0..9.
- load while busy=1 is ignored entirely; there is no queueing.
- load held high: a new conversion is accepted on the edge after done (busy=0 that cycle). Back-to-back period is 9 cycles.
- bcd and the display keep the previous committed value for the whole conversion; there are no intermediate values on seg.
- Scan sequencing:
  - The scan counter counts 0..SCAN_DIV-1 and wraps to 0.
  - On the wrap edge the digit index advances 0→1→2→0.
  - With SCAN_DIV=1 the index advances every cycle.
  - The scan runs continuously and independently of the conversion state.
- an and seg are combinational decodes of the registered digit index and the bcd register. Index 0/1/2 gives an = 110/101/011.
- seg encoding, active low, for nibble 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000. Nibbles 10..15 are blank (1111111); they are unreachable.
- Reset mid-conversion aborts the conversion: no done pulse, bcd=0, state IDLE, scan restarts at index 0.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: when the hundreds digit is 0, its slot drives seg=1111111. When hundreds and tens are both 0, the tens slot is also blank. The units digit is always shown. an sequencing is unchanged.
- Undefined: all three digits are always shown, including leading zeros.

Test Plan:
- Reset, then load=1 with value_in=8'd255 for one cycle → busy high 8 cycles; done pulses 8 cycles after the load edge; bcd=12'h255.
- Load 8'd0, then 8'd100, then 8'd9 in sequence → bcd=12'h000, 12'h100, 12'h009 in turn, each with one done pulse.
- Load 8'd42; pulse load with 8'd200 three cycles later (busy=1) → second load ignored; bcd=12'h042; exactly one done.
- SCAN_DIV=4 with bcd=12'h137 → an cycles 110, 101, 011 every 4 cycles; seg = 1111000, 0110000, 1111001 respectively.
- Load 8'd199; assert reset at cycle 4 of CONV → no done; bcd=12'h000; an=110; seg=1000000.
- With LEADING_ZERO_BLANK_EN defined, load 8'd7 → units seg=1111000; tens and hundreds seg=1111111. Load 8'd0 → units shows 1000000.

Source files
------------

// File: rtl/d7s_scan_ctrl.sv
// Three-digit seven-segment controller: 8-bit binary to BCD (shift-add-3, one step per cycle) plus digit scan.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits.
module d7s_scan_ctrl #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  value_in,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd,
    output logic [6:0]  seg,
    output logic [2:0]  an
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         shift_q, shift_d;
    logic [11:0]        scratch_q, scratch_d;
    logic [2:0]         step_q, step_d;
    logic [11:0]        bcd_q, bcd_d;
    logic               done_q, done_d;
    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [1:0]         digit_idx_q, digit_idx_d;

    logic [11:0]        adj;
    logic [19:0]        shifted;

    // Each BCD nibble that would overflow past 9 after doubling gets +3 first.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_add3
            assign adj[gi*4 +: 4] = (scratch_q[gi*4 +: 4] >= 4'd5) ?
                                    scratch_q[gi*4 +: 4] + 4'd3 :
                                    scratch_q[gi*4 +: 4];
        end
    endgenerate

    assign shifted = {adj, shift_q} << 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            scratch_q   <= '0;
            step_q      <= '0;
            bcd_q       <= '0;
            done_q      <= 1'b0;
            scan_cnt_q  <= '0;
            digit_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            scratch_q   <= scratch_d;
            step_q      <= step_d;
            bcd_q       <= bcd_d;
            done_q      <= done_d;
            scan_cnt_q  <= scan_cnt_d;
            digit_idx_q <= digit_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        step_d    = step_q;
        bcd_d     = bcd_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    shift_d   = value_in;
                    scratch_d = '0;
                    step_d    = '0;
                    state_d   = CONV;
                end
            end
            CONV: begin
                scratch_d = shifted[19:8];
                shift_d   = shifted[7:0];
                step_d    = step_q + 3'd1;
                // Eighth shift: commit the finished digits directly from the shift path.
                if (step_q == 3'd7) begin
                    bcd_d   = shifted[19:8];
                    done_d  = 1'b1;
                    step_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        scan_cnt_d  = scan_cnt_q + 1'b1;
        digit_idx_d = digit_idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d  = '0;
            digit_idx_d = (digit_idx_q == 2'd2) ? 2'd0 : digit_idx_q + 2'd1;
        end
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [3:0] nibble;
    logic       blank;

    always_comb begin
        nibble = bcd_q[3:0];
        an     = 3'b111;
        blank  = 1'b0;
        case (digit_idx_q)
            2'd0: begin
                nibble = bcd_q[3:0];
                an     = 3'b110;
            end
            2'd1: begin
                nibble = bcd_q[7:4];
                an     = 3'b101;
`ifdef LEADING_ZERO_BLANK_EN
                blank  = (bcd_q[11:4] == 8'h00);
`endif
            end
            2'd2: begin
                nibble = bcd_q[11:8];
                an     = 3'b011;
`ifdef LEADING_ZERO_BLANK_EN
                blank  = (bcd_q[11:8] == 4'h0);
`endif
            end
            default: begin
                nibble = bcd_q[3:0];
                an     = 3'b111;
            end
        endcase
        seg = blank ? 7'b1111111 : seg_decode(nibble);
    end

    assign busy = (state_q == CONV);
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_d7s_scan_ctrl.sv
// Self-checking bench for d7s_scan_ctrl: decimal-arithmetic reference for BCD, cycle-count reference for the scan.
module tb_d7s_scan_ctrl;

    localparam int SCAN_DIV = 4;

    logic        clk;
    logic        reset;
    logic [7:0]  value_in;
    logic        load;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
    logic [6:0]  seg;
    logic [2:0]  an;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [11:0] exp_bcd = 12'h000;
    logic [6:0]  seg_tab [0:9];

    d7s_scan_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .value_in (value_in),
        .load     (load),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .seg      (seg),
        .an       (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Non-reset edges since the last reset edge; the scan position follows from this alone.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] h, t, u;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {h, t, u};
    endfunction

    function automatic logic [6:0] exp_seg(input int idx, input logic [11:0] b);
        int h, t, u;
        h = int'(b[11:8]);
        t = int'(b[7:4]);
        u = int'(b[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
        if (idx == 2 && h == 0) return 7'b1111111;
        if (idx == 1 && h == 0 && t == 0) return 7'b1111111;
`endif
        if (idx == 0) return seg_tab[u];
        if (idx == 1) return seg_tab[t];
        return seg_tab[h];
    endfunction

    function automatic logic [2:0] exp_an(input int idx);
        logic [2:0] one;
        one = 3'b001 << idx;
        return ~one;
    endfunction

    // Runs one conversion from IDLE; checks busy/done/bcd every cycle through the commit.
    task automatic do_convert(input logic [7:0] v, input string name);
        logic [11:0] want;
        want = to_bcd(int'(v));
        @(negedge clk);
        value_in = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({busy, done, bcd} !== {1'b1, 1'b0, exp_bcd}) begin
                errors++;
                $display("FAIL %s_conv_cyc%0d: busy=%b done=%b bcd=%h required busy=1 done=0 bcd=%h",
                         name, i, busy, done, bcd, exp_bcd);
            end
            @(negedge clk);
        end
        checks++;
        if ({busy, done, bcd} !== {1'b0, 1'b1, want}) begin
            errors++;
            $display("FAIL %s_commit: busy=%b done=%b bcd=%h required busy=0 done=1 bcd=%h",
                     name, busy, done, bcd, want);
        end
        exp_bcd = want;
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_width: done=%b required 0", name, done);
        end
    endtask

    task automatic check_scan(input int ncyc, input string name);
        int idx;
        for (int i = 0; i < ncyc; i++) begin
            idx = (cyc / SCAN_DIV) % 3;
            checks++;
            if (an !== exp_an(idx) || seg !== exp_seg(idx, exp_bcd)) begin
                errors++;
                $display("FAIL %s_scan: an=%b seg=%b required an=%b seg=%b (bcd %h)",
                         name, an, seg, exp_an(idx), exp_seg(idx, exp_bcd), exp_bcd);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, bcd, an, seg} !== {1'b0, 1'b0, 12'h000, 3'b110, 7'b1000000}) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b bcd=%h an=%b seg=%b required 0 0 000 110 1000000",
                     busy, done, bcd, an, seg);
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        do_convert(8'd255, "load255");
        $display("test_single: 255 -> %h", bcd);
    endtask

    task automatic test_sequence();
        do_convert(8'd0, "load0");
        do_convert(8'd100, "load100");
        do_convert(8'd9, "load9");
        $display("test_sequence: last bcd %h", bcd);
    endtask

    task automatic test_ignore_busy();
        int dones;
        dones = 0;
        @(negedge clk);
        value_in = 8'd42;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) begin
                value_in = 8'd200;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        exp_bcd = to_bcd(42);
        checks++;
        if (dones != 1 || bcd !== exp_bcd) begin
            errors++;
            $display("FAIL ignore_busy: dones=%0d bcd=%h required dones=1 bcd=%h", dones, bcd, exp_bcd);
        end
        $display("test_ignore_busy: dones=%0d bcd=%h", dones, bcd);
    endtask

    task automatic test_scan();
        do_convert(8'd137, "load137");
        check_scan(3 * SCAN_DIV * 2 + 1, "bcd137");
        $display("test_scan done");
    endtask

    task automatic test_leading_zero();
        do_convert(8'd7, "load7");
        check_scan(3 * SCAN_DIV, "bcd007");
        do_convert(8'd0, "load0b");
        check_scan(3 * SCAN_DIV, "bcd000");
        do_convert(8'd56, "load56");
        check_scan(3 * SCAN_DIV, "bcd056");
        $display("test_leading_zero done");
    endtask

    task automatic test_reset_mid();
        int dones;
        dones = 0;
        @(negedge clk);
        value_in = 8'd199;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_bcd = 12'h000;
        checks++;
        if ({busy, done, bcd, an, seg} !== {1'b0, 1'b0, 12'h000, 3'b110, 7'b1000000}) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b bcd=%h an=%b seg=%b required 0 0 000 110 1000000",
                     busy, done, bcd, an, seg);
        end
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones != 0 || bcd !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid_nodone: dones=%0d bcd=%h required 0 000", dones, bcd);
        end
        $display("test_reset_mid: dones=%0d", dones);
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [0:4];
        logic [11:0] want;
        for (int k = 0; k < 5; k++) vals[k] = 8'($urandom_range(0, 255));
        @(negedge clk);
        value_in = vals[0];
        load = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k < 3) value_in = vals[k + 1];
            else       load = 1'b0;
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_accept%0d: busy=%b required 1", k, busy);
            end
            repeat (8) @(negedge clk);
            want = to_bcd(int'(vals[k]));
            checks++;
            if ({busy, done, bcd} !== {1'b0, 1'b1, want}) begin
                errors++;
                $display("FAIL b2b_commit%0d: busy=%b done=%b bcd=%h required 0 1 %h",
                         k, busy, done, bcd, want);
            end
            exp_bcd = want;
            $display("back_to_back %0d: value %0d -> bcd %h", k, vals[k], bcd);
        end
        @(negedge clk);
        check_scan(3 * SCAN_DIV, "b2b");
    endtask

    task automatic test_random();
        logic [7:0] v;
        for (int n = 0; n < 20; n++) begin
            v = 8'($urandom_range(0, 255));
            do_convert(v, "rand");
            check_scan(int'($urandom_range(1, 14)), "rand");
            $display("random %0d: value %0d -> bcd %h", n, v, bcd);
        end
    endtask

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
        seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
        seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;
        reset = 1'b1;
        load = 1'b0;
        value_in = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_single();
        test_sequence();
        test_ignore_busy();
        test_scan();
        test_leading_zero();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
